// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encoding, widths and address helper for the data-memory access controller.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package mem_ctrl_pkg;

  localparam int WORD_W             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int TMO_CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [WORD_W-1:0] word_t;

  function automatic logic word_aligned(input word_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus: controller is master, memory is slave.
// Request is level-held by the master until the slave answers with mem_ready.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  logic  mem_ready;
  word_t mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_timeout_counter.sv
// Counts enabled cycles from clear; tc is combinational from the count (no added latency).
// No backpressure: holds at terminal count until cleared.
module timeout_counter
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TMO_CNT_W-1:0] TC_VAL = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data access controller: IDLE -> REQ -> DONE, min 3 cycles per access.
// Stalls the pipeline combinationally while an access is open; memory backpressures by withholding mem_ready.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit STATS_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwriteM,
  input  logic              memtoregM,
  input  word_t             aluoutM,
  input  word_t             writedataM,
  mem_access_ctrl_if.master mem,
  output logic              stallM,
  output word_t             readdataM,
  output logic              exc_align,
  output logic              exc_timeout,
  output logic              busy,
  output logic [WORD_W-1:0] stall_cnt
);

  state_t state_q, state_d;

  logic  memop;
  logic  aligned;
  logic  accept;
  logic  timeout;
  logic  tmo_clear;
  logic  tmo_en;
  logic  tmo_tc;
  logic  stall_inc;

  logic  mem_req_q;
  logic  mem_we_q;
  word_t addr_q;
  word_t wdata_q;
  word_t rdata_q;
  logic  exc_align_q;
  logic  exc_timeout_q;
  logic [WORD_W-1:0] stall_cnt_q;

  // A store wins when both flags are set; mem_we below carries that choice.
  assign memop   = memwriteM | memtoregM;
  assign aligned = word_aligned(aluoutM);

  // mem_ready only matters while a request is open; it beats the timeout on a tie.
  assign accept  = (state_q == REQ) && mem.mem_ready;
  assign timeout = (state_q == REQ) && !mem.mem_ready && tmo_tc;

  assign tmo_clear = (state_q != REQ);
  assign tmo_en    = (state_q == REQ) && !mem.mem_ready;

  timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .tc     (tmo_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memop) state_d = aligned ? REQ : DONE;
      REQ:     if (accept || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Releasing the stall in DONE lets the Memory-stage instruction advance at the end of DONE.
  always_comb begin
    stallM = memop && (state_q != DONE);
    busy   = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      exc_align_q   <= 1'b0;
      exc_timeout_q <= 1'b0;
    end else begin
      exc_align_q   <= (state_q == IDLE) && memop && !aligned;
      exc_timeout_q <= timeout;
      case (state_q)
        IDLE: begin
          if (memop && aligned) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= memwriteM;
            addr_q    <= aluoutM;
            wdata_q   <= writedataM;
          end
        end
        REQ: begin
          if (accept || timeout) mem_req_q <= 1'b0;
          if (accept && !mem_we_q) rdata_q <= mem.mem_rdata;
        end
        default: mem_req_q <= 1'b0;
      endcase
    end
  end

  assign stall_inc = STATS_EN && stallM && (stall_cnt_q != '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {{(WORD_W-1){1'b0}}, stall_inc};
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign readdataM     = rdata_q;
  assign exc_align     = exc_align_q;
  assign exc_timeout   = exc_timeout_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: default-timeout instance plus a TIMEOUT_CYCLES=4 instance.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwriteM = 1'b0;
  logic        memtoregM = 1'b0;
  logic [31:0] aluoutM = '0;
  logic [31:0] writedataM = '0;
  logic        stallM, exc_align, exc_timeout, busy;
  logic [31:0] readdataM, stall_cnt;

  logic        b_memtoreg = 1'b0;
  logic [31:0] b_aluout = '0;
  logic        b_stallM, b_exc_align, b_exc_timeout, b_busy;
  logic [31:0] b_readdata, b_stall_cnt;

  int total = 0;
  int bad = 0;
  int req_cycles;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if b_bus ();

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .memwriteM(memwriteM), .memtoregM(memtoregM),
    .aluoutM(aluoutM), .writedataM(writedataM), .mem(bus), .stallM(stallM),
    .readdataM(readdataM), .exc_align(exc_align), .exc_timeout(exc_timeout),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .reset(reset), .memwriteM(1'b0), .memtoregM(b_memtoreg),
    .aluoutM(b_aluout), .writedataM(32'h0), .mem(b_bus), .stallM(b_stallM),
    .readdataM(b_readdata), .exc_align(b_exc_align), .exc_timeout(b_exc_timeout),
    .busy(b_busy), .stall_cnt(b_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    b_bus.mem_ready = 1'b0; b_bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
    total++; if (readdataM !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", readdataM); end
    total++; if ({exc_align, exc_timeout} !== 2'b00) begin bad++; $display("FAIL rst_exc: got %b want 00", {exc_align, exc_timeout}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
    total++; if (stallM !== 1'b0) begin bad++; $display("FAIL rst_stallM: got %b want 0", stallM); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_load();
    @(negedge clk); memtoregM = 1'b1; aluoutM = 32'h10; #1;
    total++; if (stallM !== 1'b1) begin bad++; $display("FAIL load_idle_stall: got %b want 1", stallM); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL load_idle_req: got %b want 0", bus.mem_req); end
    @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #1;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL load_req: got %b want 1", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL load_addr: got %h want 00000010", bus.mem_addr); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL load_we: got %b want 0", bus.mem_we); end
    total++; if ({stallM, busy} !== 2'b11) begin bad++; $display("FAIL load_req_stall_busy: got %b want 11", {stallM, busy}); end
    @(negedge clk); bus.mem_ready = 1'b0; bus.mem_rdata = '0; #1;
    total++; if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", readdataM); end
    total++; if ({stallM, bus.mem_req} !== 2'b00) begin bad++; $display("FAIL load_done_stall_req: got %b want 00", {stallM, bus.mem_req}); end
    total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL load_stall_cnt: got %0d want 2", stall_cnt); end
    total++; if ({exc_align, exc_timeout} !== 2'b00) begin bad++; $display("FAIL load_exc: got %b want 00", {exc_align, exc_timeout}); end
    @(negedge clk); memtoregM = 1'b0; #1;
    total++; if ({busy, stallM} !== 2'b00) begin bad++; $display("FAIL load_idle_after: got %b want 00", {busy, stallM}); end
  endtask

  task automatic test_store();
    @(negedge clk); memwriteM = 1'b1; aluoutM = 32'h20; writedataM = 32'h12345678; #1;
    total++; if ({stallM, bus.mem_req} !== 2'b10) begin bad++; $display("FAIL store_idle: got %b want 10", {stallM, bus.mem_req}); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); bus.mem_ready = (k == 5); bus.mem_rdata = 32'hFFFF0000; #1;
      total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL store_req_c%0d: got %b want 1", k, bus.mem_req); end
      total++; if (bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin bad++; $display("FAIL store_stable_c%0d: got %h/%h want 00000020/12345678", k, bus.mem_addr, bus.mem_wdata); end
      total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL store_we_c%0d: got %b want 1", k, bus.mem_we); end
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL store_done_req: got %b want 0", bus.mem_req); end
    total++; if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL store_rdata_kept: got %h want deadbeef", readdataM); end
    total++; if (stall_cnt !== 32'd8) begin bad++; $display("FAIL store_stall_cnt: got %0d want 8", stall_cnt); end
    total++; if ({stallM, exc_timeout} !== 2'b00) begin bad++; $display("FAIL store_done_flags: got %b want 00", {stallM, exc_timeout}); end
    @(negedge clk); memwriteM = 1'b0; writedataM = '0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL store_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_align();
    @(negedge clk); memtoregM = 1'b1; aluoutM = 32'h13; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13131313; #1;
    total++; if ({stallM, bus.mem_req, exc_align} !== 3'b100) begin bad++; $display("FAIL align_idle: got %b want 100", {stallM, bus.mem_req, exc_align}); end
    @(negedge clk); #1;
    total++; if (exc_align !== 1'b1) begin bad++; $display("FAIL align_exc: got %b want 1", exc_align); end
    total++; if ({bus.mem_req, stallM, busy} !== 3'b001) begin bad++; $display("FAIL align_done: got %b want 001", {bus.mem_req, stallM, busy}); end
    total++; if (stall_cnt !== 32'd9) begin bad++; $display("FAIL align_stall_cnt: got %0d want 9", stall_cnt); end
    @(negedge clk); memtoregM = 1'b0; bus.mem_ready = 1'b0; #1;
    total++; if ({exc_align, busy} !== 2'b00) begin bad++; $display("FAIL align_after: got %b want 00", {exc_align, busy}); end
    total++; if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL align_rdata_kept: got %h want deadbeef", readdataM); end
  endtask

  task automatic test_timeout();
    @(negedge clk); b_memtoreg = 1'b1; b_aluout = 32'h40; b_bus.mem_ready = 1'b0; #1;
    total++; if ({b_stallM, b_bus.mem_req} !== 2'b10) begin bad++; $display("FAIL tmo_idle: got %b want 10", {b_stallM, b_bus.mem_req}); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      total++; if ({b_bus.mem_req, b_exc_timeout} !== 2'b10) begin bad++; $display("FAIL tmo_req_c%0d: got %b want 10", k, {b_bus.mem_req, b_exc_timeout}); end
    end
    @(negedge clk); #1;
    total++; if (b_exc_timeout !== 1'b1) begin bad++; $display("FAIL tmo_exc: got %b want 1", b_exc_timeout); end
    total++; if ({b_bus.mem_req, b_stallM} !== 2'b00) begin bad++; $display("FAIL tmo_done: got %b want 00", {b_bus.mem_req, b_stallM}); end
    total++; if (b_readdata !== 32'h0) begin bad++; $display("FAIL tmo_rdata_kept: got %h want 0", b_readdata); end
    @(negedge clk); b_memtoreg = 1'b0; #1;
    total++; if ({b_exc_timeout, b_busy} !== 2'b00) begin bad++; $display("FAIL tmo_after: got %b want 00", {b_exc_timeout, b_busy}); end
    @(negedge clk); b_memtoreg = 1'b1; b_aluout = 32'h44; #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); b_bus.mem_ready = (k == 4); b_bus.mem_rdata = 32'hCAFEF00D; #1;
      total++; if (b_bus.mem_req !== 1'b1) begin bad++; $display("FAIL tmo2_req_c%0d: got %b want 1", k, b_bus.mem_req); end
    end
    @(negedge clk); b_bus.mem_ready = 1'b0; #1;
    total++; if (b_exc_timeout !== 1'b0) begin bad++; $display("FAIL tmo2_ready_wins: got %b want 0", b_exc_timeout); end
    total++; if (b_readdata !== 32'hCAFEF00D) begin bad++; $display("FAIL tmo2_rdata: got %h want cafef00d", b_readdata); end
    total++; if (b_stall_cnt !== 32'd10) begin bad++; $display("FAIL tmo_stall_cnt: got %0d want 10", b_stall_cnt); end
    @(negedge clk); b_memtoreg = 1'b0; #1;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk); memtoregM = 1'b1; aluoutM = 32'h50; bus.mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req1: got %b want 1", bus.mem_req); end
    @(negedge clk); #1;
    total++; if ({bus.mem_req, busy} !== 2'b11) begin bad++; $display("FAIL rmid_req2: got %b want 11", {bus.mem_req, busy}); end
    reset = 1'b1; #1;
    total++; if ({bus.mem_req, busy} !== 2'b00) begin bad++; $display("FAIL rmid_drop: got %b want 00", {bus.mem_req, busy}); end
    total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL rmid_stall_cnt: got %0d want 0", stall_cnt); end
    total++; if (readdataM !== 32'h0 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rmid_regs: got %h/%h want 0/0", readdataM, bus.mem_addr); end
    @(negedge clk); memtoregM = 1'b0; reset = 1'b0;
    @(negedge clk); memtoregM = 1'b1; aluoutM = 32'h60; #1;
    total++; if ({stallM, busy} !== 2'b10) begin bad++; $display("FAIL rmid_new_idle: got %b want 10", {stallM, busy}); end
    @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D; #1;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h60) begin bad++; $display("FAIL rmid_new_req: got %b/%h want 1/00000060", bus.mem_req, bus.mem_addr); end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    total++; if (readdataM !== 32'h0BADF00D) begin bad++; $display("FAIL rmid_new_rdata: got %h want 0badf00d", readdataM); end
    total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL rmid_new_stall_cnt: got %0d want 2", stall_cnt); end
    @(negedge clk); memtoregM = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    req_cycles = 0;
    @(negedge clk); memtoregM = 1'b1; aluoutM = 32'h70; #1;
    if (bus.mem_req === 1'b1) req_cycles++;
    total++; if ({stallM, busy} !== 2'b10) begin bad++; $display("FAIL b2b_ld_idle: got %b want 10", {stallM, busy}); end
    @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11112222; #1;
    if (bus.mem_req === 1'b1) req_cycles++;
    total++; if (stallM !== 1'b1) begin bad++; $display("FAIL b2b_ld_req_stall: got %b want 1", stallM); end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    if (bus.mem_req === 1'b1) req_cycles++;
    total++; if (readdataM !== 32'h11112222 || stallM !== 1'b0) begin bad++; $display("FAIL b2b_ld_done: got %h/%b want 11112222/0", readdataM, stallM); end
    // Store issued with both flags set: must be treated as a store.
    @(negedge clk); memwriteM = 1'b1; aluoutM = 32'h74; writedataM = 32'h55AA55AA; #1;
    if (bus.mem_req === 1'b1) req_cycles++;
    total++; if ({stallM, busy} !== 2'b10) begin bad++; $display("FAIL b2b_st_idle: got %b want 10", {stallM, busy}); end
    @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99999999; #1;
    if (bus.mem_req === 1'b1) req_cycles++;
    total++; if (bus.mem_addr !== 32'h74 || bus.mem_wdata !== 32'h55AA55AA || bus.mem_we !== 1'b1) begin bad++; $display("FAIL b2b_st_req: got %h/%h/%b want 00000074/55aa55aa/1", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    if (bus.mem_req === 1'b1) req_cycles++;
    total++; if (readdataM !== 32'h11112222 || stallM !== 1'b0) begin bad++; $display("FAIL b2b_st_done: got %h/%b want 11112222/0", readdataM, stallM); end
    @(negedge clk); memwriteM = 1'b0; memtoregM = 1'b0; writedataM = '0; #1;
    total++; if (req_cycles !== 2) begin bad++; $display("FAIL b2b_req_cycles: got %0d want 2", req_cycles); end
    total++; if (stall_cnt !== 32'd6) begin bad++; $display("FAIL b2b_stall_cnt: got %0d want 6", stall_cnt); end
  endtask

  task automatic test_saturate();
    @(negedge clk); force dut.stall_cnt_q = 32'hFFFF_FFFD;
    @(negedge clk); release dut.stall_cnt_q; #1;
    total++; if (stall_cnt !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sat_preload: got %h want fffffffd", stall_cnt); end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); memtoregM = 1'b1; aluoutM = 32'h80; #1;
      @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0; #1;
      if (n == 0) begin
        total++; if (stall_cnt !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_step: got %h want fffffffe", stall_cnt); end
      end
      @(negedge clk); bus.mem_ready = 1'b0; #1;
      total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold_%0d: got %h want ffffffff", n, stall_cnt); end
      @(negedge clk); memtoregM = 1'b0; #1;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_align();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum REQ-state cycles before abort; legal range 2..255.
REQ-002 Parameter STATS_EN, default 1: 1 enables the stall-cycle counter; 0 ties stall_cnt to 0.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memwriteM, memtoregM  input  1 each  store / load flags of the instruction in the Memory stage.
REQ-006 aluoutM  input  32  byte address of the access; writedataM  input  32  store data.
REQ-007 mem_req  output  1  data-memory request, held until accepted.
REQ-008 mem_we  output  1  store qualifier; mem_addr  output  32; mem_wdata  output  32.
REQ-009 mem_ready  input  1  memory completion; mem_rdata  input  32  load data, valid with mem_ready.
REQ-010 stallM  output  1  freezes the Fetch, Decode, Execute and Memory pipeline registers.
REQ-011 readdataM  output  32  load result, held until the next completion.
REQ-012 exc_align, exc_timeout  output  1 each  one-cycle exception flags, valid in DONE only.
REQ-013 busy  output  1  state != IDLE; stall_cnt  output  32  total stalled cycles.

Function
REQ-014 memop SHALL be defined as memwriteM | memtoregM; memwriteM has priority when both are set, so the access is treated as a store.
REQ-015 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-016 IDLE: memop with aluoutM[1:0]==0 SHALL register the address, data and mem_we=memwriteM and move to REQ.
REQ-017 IDLE: memop with aluoutM[1:0]!=0 SHALL move to DONE with exc_align=1 and issue no mem_req.
REQ-018 REQ: mem_req=1 every cycle, and mem_addr, mem_wdata and mem_we SHALL stay stable until the cycle that has mem_ready=1.
REQ-019 REQ with mem_ready=1: capture mem_rdata into readdataM only when mem_we=0; move to DONE.
REQ-020 REQ timeout counter: starts at 0 on REQ entry and increments per REQ cycle without mem_ready.
REQ-021 Timeout: when the counter equals TIMEOUT_CYCLES-1 and mem_ready=0, move to DONE with exc_timeout=1; readdataM is unchanged.
REQ-022 If mem_ready=1 occurs in the same cycle as the timeout condition, mem_ready SHALL win and exc_timeout SHALL stay 0.
REQ-023 DONE: exactly one cycle, then IDLE; mem_req=0 in DONE.
REQ-024 stallM = memop & (state != DONE), combinational, so the Memory-stage instruction advances at the end of DONE.
REQ-025 Minimum Memory-stage occupancy SHALL be 3 cycles (IDLE, REQ with mem_ready, DONE); a non-memop occupies 1 cycle with stallM=0.
REQ-026 mem_ready outside REQ SHALL be ignored.
REQ-027 stall_cnt SHALL increment on every cycle with stallM=1, saturate at 32'hFFFF_FFFF and never wrap.

Reset
REQ-028 Reset assertion SHALL immediately force: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, readdataM 0, exc_* 0, timeout counter 0, stall_cnt 0.
REQ-029 Reset during REQ SHALL drop mem_req in the same cycle without waiting for mem_ready.
REQ-030 Reset deassertion SHALL be synchronised externally; the first active edge samples inputs normally.

Structure
REQ-031 A shared package mem_ctrl_pkg SHALL hold the state enum (IDLE, REQ, DONE), the default TIMEOUT_CYCLES and the 32-bit word-width constant.
REQ-032 The REQ timeout counter SHALL be a sub-module timeout_counter (clear, enable, terminal-count output), parameterised by TIMEOUT_CYCLES.
REQ-033 All registers SHALL be in clk/reset async-reset processes; stallM is the only combinational output besides busy.

Verification
REQ-034 Load at 0x0000_0010, mem_ready in the first REQ cycle with rdata 0xDEADBEEF -> stallM high 2 cycles, readdataM=0xDEADBEEF in DONE, stall_cnt=2.
REQ-035 Store at 0x0000_0020 with data 0x1234_5678, mem_ready delayed 4 cycles -> mem_req held 5 cycles, address and data stable, mem_we=1, readdataM unchanged.
REQ-036 Load at 0x0000_0013 -> no mem_req, DONE with exc_align=1 on the second cycle, stallM high 1 cycle.
REQ-037 TIMEOUT_CYCLES=4, mem_ready never asserted -> exc_timeout=1 after 4 REQ cycles; repeat with mem_ready on the 4th REQ cycle -> exc_timeout=0.
REQ-038 Reset asserted in the 2nd REQ cycle -> mem_req=0 and busy=0 before the next edge, stall_cnt=0, and the next load completes normally.
REQ-039 Back-to-back load then store with 1-cycle mem_ready -> each occupies 3 cycles with no duplicate request; preload stall_cnt near 2^32-1 -> saturates at 32'hFFFF_FFFF.
